seq_alu: RTL and testbench

Parametrised, multi-cycle ALU with valid/ready handshakes on operand input and result output. It supports add, sub, mul, div, and, or, not and xor on WIDTH-bit operands, and reports zero, carry/borrow/overflow and divide-by-zero flags. Multiply and divide run as iterative shift-add and restoring-division sequencers. The block sits between an operand producer and a result consumer in the datapath, and replaces the combinational 8-bit ALU where a registered, back-pressurable unit is needed.

---
 rtl/seq_alu.sv | 242 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu -- registered, back-pressurable ALU with iterative multiply/divide.
//
// Accepts one operation at a time over a valid/ready handshake, computes it
// either in a single cycle (add, sub, and, or, not, xor, div by zero) or with
// a bit-serial sequencer (mul: shift-add, div: restoring division), then holds
// the result until the consumer takes it.
//
// Build option:
//   SEQ_ALU_MULDIV_EN  defined   -> mul/div sequencers present
//                      undefined -> op 010/011 finish in one cycle as illegal
//                                   ops (y = 0, div_zero = 1)
//
// Parameters:
//   WIDTH      operand/result width, 2..32
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   producer presents op/a/b
//   in_ready   block is idle and will take an op
//   op         000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or,
//              110 not a, 111 xor
//   a, b       operands
//   out_valid  y and flags hold a completed result
//   out_ready  consumer takes the result
//   y          result
//   zero       y == 0
//   carry      add carry-out / sub borrow / mul overflow, else 0
//   div_zero   div with b == 0 (illegal-op flag when mul/div are absent)

module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             carry,
   output logic             div_zero
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
      $error("seq_alu: WIDTH must be in 2..32");
   end

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_NOT = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;
   logic   accept;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   // ------------------------------------------------------------------
   // Single-cycle result, computed straight from the input operands so it
   // can be registered on the accept edge. Bit WIDTH is the carry/borrow.
   // ------------------------------------------------------------------
   logic [WIDTH:0]   sc_wide;
   logic [WIDTH-1:0] sc_y;
   logic             sc_dz;

   always_comb begin
      sc_wide = '0;
      sc_dz   = 1'b0;
      case (op)
         OP_ADD: sc_wide = {1'b0, a} + {1'b0, b};
         // Borrow falls out as bit WIDTH of the wrapped difference.
         OP_SUB: sc_wide = {1'b0, a} - {1'b0, b};
         OP_AND: sc_wide = {1'b0, a & b};
         OP_OR:  sc_wide = {1'b0, a | b};
         OP_NOT: sc_wide = {1'b0, ~a};
         OP_XOR: sc_wide = {1'b0, a ^ b};
`ifdef SEQ_ALU_MULDIV_EN
         // Only the b == 0 case of div finishes here; b != 0 goes to DIV.
         OP_DIV: begin
            sc_wide = {1'b0, {WIDTH{1'b1}}};
            sc_dz   = 1'b1;
         end
`else
         // No sequencers: mul/div are flagged as illegal with y = 0.
         OP_MUL, OP_DIV: begin
            sc_wide = '0;
            sc_dz   = 1'b1;
         end
`endif
         default: begin
            sc_wide = '0;
            sc_dz   = 1'b0;
         end
      endcase
   end

   assign sc_y = sc_wide[WIDTH-1:0];

`ifdef SEQ_ALU_MULDIV_EN
   // ------------------------------------------------------------------
   // Mul/div sequencer. hi/lo form one 2*WIDTH-bit working register:
   //   mul: hi = partial product high half, lo = multiplier shifting out
   //        as product low bits shift in
   //   div: hi = partial remainder, lo = dividend shifting out as quotient
   //        bits shift in
   // ------------------------------------------------------------------
   localparam int CW = $clog2(WIDTH) + 1;

   typedef struct packed {
      logic [WIDTH-1:0] a;   // multiplicand
      logic [WIDTH-1:0] b;   // divisor
   } opnd_t;

   opnd_t            opnd;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] hi, lo, hi_nxt, lo_nxt;
   logic [WIDTH:0]   mul_sum, div_sh, div_trial;
   logic             start_mul, start_div;

   assign start_mul = accept && (op == OP_MUL);
   assign start_div = accept && (op == OP_DIV) && (b != '0);

   always_comb begin
      hi_nxt    = hi;
      lo_nxt    = lo;
      mul_sum   = '0;
      div_sh    = '0;
      div_trial = '0;
      if (state == MUL) begin
         mul_sum          = {1'b0, hi} + (lo[0] ? {1'b0, opnd.a} : '0);
         {hi_nxt, lo_nxt} = {mul_sum, lo[WIDTH-1:1]};
      end else if (state == DIV) begin
         div_sh    = {hi, lo[WIDTH-1]};
         div_trial = div_sh - {1'b0, opnd.b};
         // Top bit set means the trial went negative: restore, quotient 0.
         if (!div_trial[WIDTH]) begin
            hi_nxt = div_trial[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = div_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opnd <= '0;
         hi   <= '0;
         lo   <= '0;
         cnt  <= '0;
      end else if (start_mul || start_div) begin
         opnd <= '{a: a, b: b};
         hi   <= '0;
         lo   <= start_mul ? b : a;
         cnt  <= CW'(WIDTH - 1);
      end else if (state == MUL || state == DIV) begin
         hi <= hi_nxt;
         lo <= lo_nxt;
         if (cnt != '0) cnt <= cnt - CW'(1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // Control
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
               if (start_mul)      state_nxt = MUL;
               else if (start_div) state_nxt = DIV;
               else                state_nxt = DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef SEQ_ALU_MULDIV_EN
         // The count==0 cycle still performs the last iteration.
         MUL, DIV: if (cnt == '0) state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Result registers: loaded on the accept edge for single-cycle ops or on
   // the final sequencer iteration, otherwise held (stable through DONE).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y        <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
`ifdef SEQ_ALU_MULDIV_EN
         if (accept && !start_mul && !start_div) begin
`else
         if (accept) begin
`endif
            y        <= sc_y;
            zero     <= (sc_y == '0);
            carry    <= sc_wide[WIDTH];
            div_zero <= sc_dz;
         end
`ifdef SEQ_ALU_MULDIV_EN
         if ((state == MUL || state == DIV) && cnt == '0) begin
            y        <= lo_nxt;
            zero     <= (lo_nxt == '0);
            // Mul overflow: any bit set in the high half of the product.
            carry    <= (state == MUL) && (hi_nxt != '0);
            div_zero <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH = 8). Reference results come from plain
// integer arithmetic on the operation definitions; handshake timing is
// checked against the expected latency of each op.

module tb_seq_alu;

   localparam int W = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   op        = 3'd0;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         in_ready, out_valid, zero, carry, div_zero;
   logic [W-1:0] y;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]   o;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   typedef struct {
      logic [W-1:0] y;
      logic [2:0]   f;     // {zero, carry, div_zero}
      int           lat;
      int           acc;
   } exp_t;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .carry(carry), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] av, bv);
      vec_t v;
      v.o = o; v.a = av; v.b = bv;
      return v;
   endfunction

   // Reference: what the op means, in unbounded integer arithmetic.
   function automatic void model(input logic [2:0] o, input logic [W-1:0] av, bv,
                                 output logic [W-1:0] ey, output logic ez, ec, edz,
                                 output int elat);
      longint unsigned x, z, r, mask;
      x = av; z = bv; r = 0;
      mask = (64'd1 << W) - 1;
      ec = 1'b0; edz = 1'b0; elat = 1;
      case (o)
         3'd0: begin r = x + z; ec = (r > mask); end
         3'd1: begin r = x - z; ec = (x < z); end
         3'd2: begin
`ifdef SEQ_ALU_MULDIV_EN
            r = x * z; ec = (r > mask); elat = W + 1;
`else
            r = 0; edz = 1'b1;
`endif
         end
         3'd3: begin
`ifdef SEQ_ALU_MULDIV_EN
            if (z == 0) begin r = mask; edz = 1'b1; end
            else begin r = x / z; elat = W + 1; end
`else
            r = 0; edz = 1'b1;
`endif
         end
         3'd4: r = x & z;
         3'd5: r = x | z;
         3'd6: r = ~x;
         default: r = x ^ z;
      endcase
      r  = r & mask;
      ey = r[W-1:0];
      ez = (r == 0);
   endfunction

   // Drives one op with out_ready low, returns what the DUT presented at the
   // first cycle out_valid was seen, and the latency in cycles. No checking.
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, bv,
                        output logic [W-1:0] oy, output logic oz, oc, odz,
                        output int olat, output bit ok);
      int n;
      ok = 1'b1;
      @(negedge clk);
      op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) ok = 1'b0;
      @(negedge clk);
      // Scramble inputs while busy; they must not matter.
      in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      olat = 1;
      while (!out_valid && olat < 100) begin @(negedge clk); olat++; end
      if (!out_valid) ok = 1'b0;
      oy = y; oz = zero; oc = carry; odz = div_zero;
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL reset handshake: got in_ready/out_valid=%b want 10", {in_ready, out_valid});
      end
      checks++;
      if (y !== '0) begin failures++; $display("FAIL reset y: got %0d want 0", y); end
      checks++;
      if ({zero, carry, div_zero} !== 3'b000) begin
         failures++;
         $display("FAIL reset flags: got %b want 000", {zero, carry, div_zero});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      vec_t         v[$];
      logic [W-1:0] oy, ey;
      logic         oz, oc, odz, ez, ec, edz;
      int           olat, elat;
      bit           ok;
      logic [2:0]   ops [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      v.push_back(mk(3'd0, 8'd7,    8'd3));
      v.push_back(mk(3'd0, 8'd200,  8'd100));
      v.push_back(mk(3'd0, 8'd255,  8'd1));
      v.push_back(mk(3'd1, 8'd3,    8'd7));
      v.push_back(mk(3'd1, 8'd5,    8'd5));
      v.push_back(mk(3'd7, 8'h5A,   8'h5A));
      v.push_back(mk(3'd6, 8'h0F,   8'h33));
      v.push_back(mk(3'd4, 8'hF0,   8'h3C));
      v.push_back(mk(3'd5, 8'h00,   8'h00));
      for (int i = 0; i < 16; i++)
         v.push_back(mk(ops[$urandom_range(5)], W'($urandom), W'($urandom)));
      foreach (v[i]) begin
         do_op(v[i].o, v[i].a, v[i].b, oy, oz, oc, odz, olat, ok);
         model(v[i].o, v[i].a, v[i].b, ey, ez, ec, edz, elat);
         checks++;
         if (!ok) begin failures++; $display("FAIL arith[%0d] handshake timeout", i); end
         checks++;
         if (oy !== ey) begin
            failures++;
            $display("FAIL arith[%0d] op=%0d a=%0d b=%0d y: got %0d want %0d", i, v[i].o, v[i].a, v[i].b, oy, ey);
         end
         checks++;
         if ({oz, oc, odz} !== {ez, ec, edz}) begin
            failures++;
            $display("FAIL arith[%0d] op=%0d flags zcd: got %b want %b", i, v[i].o, {oz, oc, odz}, {ez, ec, edz});
         end
         checks++;
         if (olat != elat) begin
            failures++;
            $display("FAIL arith[%0d] latency: got %0d want %0d", i, olat, elat);
         end
         finish_op();
      end
   endtask

   task automatic test_muldiv();
      vec_t         v[$];
      logic [W-1:0] oy, ey;
      logic         oz, oc, odz, ez, ec, edz;
      int           olat, elat;
      bit           ok;
      v.push_back(mk(3'd2, 8'd7,   8'd3));
      v.push_back(mk(3'd2, 8'd16,  8'd16));
      v.push_back(mk(3'd2, 8'd255, 8'd255));
      v.push_back(mk(3'd2, 8'd0,   8'd99));
      v.push_back(mk(3'd3, 8'd7,   8'd3));
      v.push_back(mk(3'd3, 8'd7,   8'd0));
      v.push_back(mk(3'd3, 8'd255, 8'd1));
      v.push_back(mk(3'd3, 8'd3,   8'd7));
      v.push_back(mk(3'd3, 8'd255, 8'd255));
      for (int i = 0; i < 14; i++)
         v.push_back(mk(3'($urandom_range(3, 2)), W'($urandom),
                        ($urandom_range(5) == 0) ? '0 : W'($urandom)));
      foreach (v[i]) begin
         do_op(v[i].o, v[i].a, v[i].b, oy, oz, oc, odz, olat, ok);
         model(v[i].o, v[i].a, v[i].b, ey, ez, ec, edz, elat);
         checks++;
         if (!ok) begin failures++; $display("FAIL muldiv[%0d] handshake timeout", i); end
         checks++;
         if (oy !== ey) begin
            failures++;
            $display("FAIL muldiv[%0d] op=%0d a=%0d b=%0d y: got %0d want %0d", i, v[i].o, v[i].a, v[i].b, oy, ey);
         end
         checks++;
         if ({oz, oc, odz} !== {ez, ec, edz}) begin
            failures++;
            $display("FAIL muldiv[%0d] op=%0d flags zcd: got %b want %b", i, v[i].o, {oz, oc, odz}, {ez, ec, edz});
         end
         checks++;
         if (olat != elat) begin
            failures++;
            $display("FAIL muldiv[%0d] latency: got %0d want %0d", i, olat, elat);
         end
         finish_op();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] oy, ey;
      logic         oz, oc, odz, ez, ec, edz;
      int           olat, elat;
      bit           ok;
      do_op(3'd2, 8'd13, 8'd11, oy, oz, oc, odz, olat, ok);
      model(3'd2, 8'd13, 8'd11, ey, ez, ec, edz, elat);
      checks++;
      if (!ok || oy !== ey || {oz, oc, odz} !== {ez, ec, edz}) begin
         failures++;
         $display("FAIL bp result: got y=%0d zcd=%b want y=%0d zcd=%b", oy, {oz, oc, odz}, ey, {ez, ec, edz});
      end
      // New op offered while the result is stalled.
      op = 3'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({y, zero, carry, div_zero, out_valid, in_ready} !== {ey, ez, ec, edz, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL bp hold[%0d]: got y=%0d zcd=%b ov/ir=%b want y=%0d zcd=%b ov/ir=10",
                     i, y, {zero, carry, div_zero}, {out_valid, in_ready}, ey, {ez, ec, edz});
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         failures++;
         $display("FAIL bp handshake edge: got ov/ir=%b want 01", {out_valid, in_ready});
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || y !== 8'd3) begin
         failures++;
         $display("FAIL bp next op: got ov=%b y=%0d want ov=1 y=3", out_valid, y);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      exp_t         q[$];
      exp_t         e, h;
      logic [W-1:0] ey;
      logic         ez, ec, edz;
      int           elat, cyc, last_acc, prev_lat, issued, retired;
      bit           acc_prev;
      @(negedge clk);
      out_ready = 1'b1;
      op = 3'($urandom); a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      cyc = 0; last_acc = -1; prev_lat = 0; issued = 0; retired = 0; acc_prev = 1'b0;
      while (retired < 12 && cyc < 1000) begin
         if (out_valid) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL b2b unexpected result y=%0d at cycle %0d", y, cyc);
            end else begin
               h = q.pop_front();
               if (y !== h.y || {zero, carry, div_zero} !== h.f || cyc - h.acc != h.lat) begin
                  failures++;
                  $display("FAIL b2b[%0d]: got y=%0d zcd=%b lat=%0d want y=%0d zcd=%b lat=%0d",
                           retired, y, {zero, carry, div_zero}, cyc - h.acc, h.y, h.f, h.lat);
               end
            end
            retired++;
         end
         if (acc_prev) begin
            if (issued < 12) begin
               op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            end else in_valid = 1'b0;
            acc_prev = 1'b0;
         end
         if (in_ready && in_valid) begin
            model(op, a, b, ey, ez, ec, edz, elat);
            e.y = ey; e.f = {ez, ec, edz}; e.lat = elat; e.acc = cyc;
            q.push_back(e);
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != prev_lat + 1) begin
                  failures++;
                  $display("FAIL b2b throughput: got %0d cycles want %0d", cyc - last_acc, prev_lat + 1);
               end
            end
            last_acc = cyc; prev_lat = elat; issued++; acc_prev = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (retired < 12) begin
         failures++;
         $display("FAIL b2b timeout: got %0d results want 12", retired);
      end
   endtask

   task automatic test_abort();
      logic [W-1:0] oy;
      logic         oz, oc, odz;
      int           olat, n;
      bit           ok, stale;
      // Leave a nonzero result in y so the reset clear is visible.
      do_op(3'd0, 8'd5, 8'd6, oy, oz, oc, odz, olat, ok);
      finish_op();
      @(negedge clk);
      op = 3'd3; a = 8'd200; b = 8'd7; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, y, zero, carry, div_zero} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
         failures++;
         $display("FAIL abort reset: got ir/ov=%b y=%0d zcd=%b want ir/ov=10 y=0 zcd=000",
                  {in_ready, out_valid}, y, {zero, carry, div_zero});
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      out_ready = 1'b0;
      checks++;
      if (stale) begin failures++; $display("FAIL abort stale: got out_valid=1 want 0"); end
      do_op(3'd0, 8'd1, 8'd1, oy, oz, oc, odz, olat, ok);
      checks++;
      if (!ok || oy !== 8'd2 || {oz, oc, odz} !== 3'b000 || olat != 1) begin
         failures++;
         $display("FAIL abort recovery: got y=%0d zcd=%b lat=%0d want y=2 zcd=000 lat=1", oy, {oz, oc, odz}, olat);
      end
      finish_op();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_muldiv();
      test_backpressure();
      test_back_to_back();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
